// File: rtl/rst_ckpt.sv
// Register status table with branch checkpoints for the Tomasulo dispatch stage.
// Tracks, per architectural register, whether a result is pending and which
// producer tag will deliver it. Dispatch marks entries pending, CDB broadcasts
// clear them, and a circular buffer of snapshots supports mispredict rollback.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   dispatch_*_i             destination write (tag, valid, addr, wen)
//   cdb_tag_i, cdb_valid_i   result broadcast
//   regfile_wen_onehot_o     registers whose pending tag matches the CDB this cycle
//   rd_addr_i                NUM_RD packed read addresses
//   rd_tag_o, rd_valid_o     per-port producer tag and pending flag (CDB bypassed)
//   ckpt_save_i              snapshot the post-update table into the head slot
//   ckpt_save_id_o           slot the next save will use
//   ckpt_free_i              release the oldest checkpoint
//   ckpt_restore_i/_id_i     roll back to a live checkpoint
//   ckpt_full_o, ckpt_count_o  occupancy
module rst_ckpt #(
   parameter int unsigned NUM_REGS       = 32,
   parameter int unsigned ADDR_W         = 5,
   parameter int unsigned TAG_W          = 6,
   parameter int unsigned NUM_RD         = 2,
   parameter int unsigned NUM_CKPT       = 4,
   parameter int unsigned CKPT_W         = 2,
   parameter bit          ZERO_HARDWIRED = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [TAG_W-1:0]         dispatch_tag_i,
   input  logic                     dispatch_valid_i,
   input  logic [ADDR_W-1:0]        dispatch_addr_i,
   input  logic                     dispatch_wen_i,
   input  logic [TAG_W-1:0]         cdb_tag_i,
   input  logic                     cdb_valid_i,
   output logic [NUM_REGS-1:0]      regfile_wen_onehot_o,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*TAG_W-1:0]  rd_tag_o,
   output logic [NUM_RD-1:0]        rd_valid_o,
   input  logic                     ckpt_save_i,
   output logic [CKPT_W-1:0]        ckpt_save_id_o,
   input  logic                     ckpt_free_i,
   input  logic                     ckpt_restore_i,
   input  logic [CKPT_W-1:0]        ckpt_restore_id_i,
   output logic                     ckpt_full_o,
   output logic [CKPT_W:0]          ckpt_count_o
);

   logic [NUM_REGS-1:0]                         valid_q, valid_d, post_valid;
   logic [NUM_REGS-1:0][TAG_W-1:0]              tag_q, tag_d, post_tag;
   logic [NUM_CKPT-1:0][NUM_REGS-1:0]           ck_valid_q, ck_valid_d, ck_match;
   logic [NUM_CKPT-1:0][NUM_REGS-1:0][TAG_W-1:0] ck_tag_q, ck_tag_d;
   logic [CKPT_W-1:0]                           head_q, head_d, tail_q, tail_d;
   logic [CKPT_W:0]                             count_q, count_d;
   logic [NUM_REGS-1:0]                         match;
   logic                                        dispatch_we, full, do_save, do_free;

   // CDB tag match against the live table and against every checkpoint slot.
   always_comb begin
      match    = '0;
      ck_match = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         match[i] = cdb_valid_i & valid_q[i] & (tag_q[i] == cdb_tag_i);
         for (int s = 0; s < NUM_CKPT; s++) begin
            ck_match[s][i] = cdb_valid_i & ck_valid_q[s][i] & (ck_tag_q[s][i] == cdb_tag_i);
         end
      end
   end

   assign dispatch_we = dispatch_valid_i & dispatch_wen_i &
                        ~(ZERO_HARDWIRED && (dispatch_addr_i == '0));

   // Table as it will look after this cycle's CDB clear and dispatch write;
   // the write is applied last so it wins over a same-cycle clear.
   always_comb begin
      post_valid = valid_q & ~match;
      post_tag   = tag_q;
      if (dispatch_we) begin
         post_valid[dispatch_addr_i] = 1'b1;
         post_tag[dispatch_addr_i]   = dispatch_tag_i;
      end
   end

   assign full    = (count_q == (CKPT_W+1)'(NUM_CKPT));
   assign do_save = ckpt_save_i & ~full & ~ckpt_restore_i;
   assign do_free = ckpt_free_i & (count_q != '0) & ~ckpt_restore_i;

   // head/tail rely on natural wrap, so NUM_CKPT must equal 2**CKPT_W.
   always_comb begin
      valid_d    = post_valid;
      tag_d      = post_tag;
      ck_valid_d = ck_valid_q & ~ck_match;
      ck_tag_d   = ck_tag_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (ckpt_restore_i) begin
         valid_d = ck_valid_d[ckpt_restore_id_i];
         tag_d   = ck_tag_q[ckpt_restore_id_i];
         // The restored slot and everything younger are released.
         head_d  = ckpt_restore_id_i;
         count_d = {1'b0, ckpt_restore_id_i - tail_q};
      end else begin
         if (do_save) begin
            ck_valid_d[head_q] = post_valid;
            ck_tag_d[head_q]   = post_tag;
            head_d             = head_q + CKPT_W'(1);
         end
         if (do_free) begin
            tail_d = tail_q + CKPT_W'(1);
         end
         if (do_save && !do_free) begin
            count_d = count_q + (CKPT_W+1)'(1);
         end else if (!do_save && do_free) begin
            count_d = count_q - (CKPT_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= '0;
         tag_q      <= '0;
         ck_valid_q <= '0;
         ck_tag_q   <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         ck_valid_q <= ck_valid_d;
         ck_tag_q   <= ck_tag_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Read ports see the CDB clear of this cycle but not the dispatch write.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a                          = rd_addr_i[k*ADDR_W +: ADDR_W];
      assign rd_valid_o[k]              = valid_q[a] & ~match[a];
      assign rd_tag_o[k*TAG_W +: TAG_W] = tag_q[a];
   end

   assign regfile_wen_onehot_o = match;
   assign ckpt_save_id_o       = head_q;
   assign ckpt_full_o          = full;
   assign ckpt_count_o         = count_q;

endmodule

// File: tb/tb_rst_ckpt.sv
module tb_rst_ckpt;
   localparam int NR = 32;
   localparam int NC = 4;

   logic        clk, rst_n;
   logic [5:0]  dispatch_tag;
   logic        dispatch_valid, dispatch_wen;
   logic [4:0]  dispatch_addr;
   logic [5:0]  cdb_tag;
   logic        cdb_valid;
   logic [31:0] wen;
   logic [9:0]  rd_addr;
   logic [11:0] rd_tag;
   logic [1:0]  rd_valid;
   logic        ckpt_save, ckpt_free, ckpt_restore, ckpt_full;
   logic [1:0]  ckpt_save_id, ckpt_restore_id;
   logic [2:0]  ckpt_count;

   int n_vec = 0;
   int n_err = 0;

   rst_ckpt #(
      .NUM_REGS(32), .ADDR_W(5), .TAG_W(6), .NUM_RD(2), .NUM_CKPT(4), .CKPT_W(2),
      .ZERO_HARDWIRED(1'b1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .dispatch_tag_i(dispatch_tag), .dispatch_valid_i(dispatch_valid),
      .dispatch_addr_i(dispatch_addr), .dispatch_wen_i(dispatch_wen),
      .cdb_tag_i(cdb_tag), .cdb_valid_i(cdb_valid),
      .regfile_wen_onehot_o(wen),
      .rd_addr_i(rd_addr), .rd_tag_o(rd_tag), .rd_valid_o(rd_valid),
      .ckpt_save_i(ckpt_save), .ckpt_save_id_o(ckpt_save_id),
      .ckpt_free_i(ckpt_free), .ckpt_restore_i(ckpt_restore),
      .ckpt_restore_id_i(ckpt_restore_id),
      .ckpt_full_o(ckpt_full), .ckpt_count_o(ckpt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: current table plus an ordered list of live snapshots,
   // oldest first; m_tail is the slot id of the oldest one.
   typedef struct packed {
      logic [31:0]      v;
      logic [31:0][5:0] t;
   } snap_t;

   snap_t m_tab;
   snap_t m_q[$];
   int    m_tail;

   function automatic logic [31:0] m_match(snap_t s);
      logic [31:0] r = '0;
      for (int i = 0; i < NR; i++) r[i] = cdb_valid && s.v[i] && (s.t[i] == cdb_tag);
      return r;
   endfunction

   function automatic int m_save_id();
      return (m_tail + m_q.size()) % NC;
   endfunction

   task automatic model_reset();
      m_tab  = '0;
      m_q.delete();
      m_tail = 0;
   endtask

   task automatic model_step();
      snap_t       post, s;
      int          p;
      bit          sv, fr;
      logic [31:0] mt;
      mt = m_match(m_tab);
      for (int j = 0; j < m_q.size(); j++) begin
         s      = m_q[j];
         s.v    = s.v & ~m_match(s);
         m_q[j] = s;
      end
      if (ckpt_restore) begin
         p = (int'(ckpt_restore_id) - m_tail + NC) % NC;
         if (p >= m_q.size()) begin
            $display("FAIL restore_illegal: id %0d not live (live count %0d)", ckpt_restore_id,
                     m_q.size());
            n_err++;
         end else begin
            m_tab = m_q[p];
            while (m_q.size() > p) void'(m_q.pop_back());
         end
      end else begin
         post   = m_tab;
         post.v = post.v & ~mt;
         if (dispatch_valid && dispatch_wen && dispatch_addr != 5'd0) begin
            post.v[dispatch_addr] = 1'b1;
            post.t[dispatch_addr] = dispatch_tag;
         end
         sv    = ckpt_save && (m_q.size() < NC);
         fr    = ckpt_free && (m_q.size() > 0);
         m_tab = post;
         if (fr) begin
            void'(m_q.pop_front());
            m_tail = (m_tail + 1) % NC;
         end
         if (sv) m_q.push_back(post);
      end
   endtask

   task automatic idle();
      dispatch_tag = '0; dispatch_valid = 1'b0; dispatch_addr = '0; dispatch_wen = 1'b0;
      cdb_tag = '0; cdb_valid = 1'b0; rd_addr = '0;
      ckpt_save = 1'b0; ckpt_free = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
   endtask

   task automatic dispatch(input int a, input int t);
      dispatch_valid = 1'b1; dispatch_wen = 1'b1;
      dispatch_addr = 5'(a); dispatch_tag = 6'(t);
   endtask

   // Advance one clock: update the model with the inputs of this cycle.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      cdb_valid = 1'b1;  // tag 0 must not match entries that are not pending
      rd_addr = {5'd3, 5'd0};
      model_reset();
      #2;
      n_vec++; if (wen !== 32'd0) begin $display("FAIL reset_wen got %h exp 0", wen); n_err++; end
      n_vec++; if (rd_valid !== 2'b00) begin
         $display("FAIL reset_rd_valid got %b exp 00", rd_valid); n_err++; end
      n_vec++; if (ckpt_count !== 3'd0 || ckpt_full !== 1'b0 || ckpt_save_id !== 2'd0) begin
         $display("FAIL reset_ckpt got cnt=%0d full=%b id=%0d exp 0/0/0", ckpt_count, ckpt_full,
                  ckpt_save_id);
         n_err++;
      end
      #10 rst_n = 1'b1;
      idle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_read_clear();
      logic [31:0] one = 32'd1;
      for (int i = 1; i < NR; i++) begin
         idle(); dispatch(i, i); tick();
      end
      idle(); dispatch(0, 7); tick();
      idle();
      for (int r = 0; r < NR; r++) begin
         rd_addr = {5'(r), 5'(r)};
         #1;
         n_vec++;
         if (rd_valid !== ((r != 0) ? 2'b11 : 2'b00) || rd_tag !== {6'(r), 6'(r)}) begin
            $display("FAIL fill_read r%0d got v=%b t=%h exp v=%b t=%h", r, rd_valid, rd_tag,
                     (r != 0) ? 2'b11 : 2'b00, {6'(r), 6'(r)});
            n_err++;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 1; i < NR; i++) begin
         idle(); cdb_valid = 1'b1; cdb_tag = 6'(i);
         #2;
         n_vec++;
         if (wen !== (one << i)) begin
            $display("FAIL cdb_onehot tag%0d got %h exp %h", i, wen, one << i); n_err++;
         end
         tick();
      end
      idle();
      for (int r = 0; r < NR; r++) begin
         rd_addr = {5'(r), 5'(r)};
         #1;
         n_vec++;
         if (rd_valid !== 2'b00) begin
            $display("FAIL cleared r%0d got v=%b exp 00", r, rd_valid); n_err++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_collision();
      idle(); dispatch(5, 3); tick();
      idle(); dispatch(5, 9); cdb_valid = 1'b1; cdb_tag = 6'd3;
      #2;
      n_vec++; if (wen !== 32'h0000_0020) begin
         $display("FAIL collision_onehot got %h exp 00000020", wen); n_err++; end
      tick();
      idle(); rd_addr = {5'd0, 5'd5};
      #2;
      n_vec++; if (rd_valid[0] !== 1'b1 || rd_tag[5:0] !== 6'd9) begin
         $display("FAIL collision_entry got v=%b t=%0d exp v=1 t=9", rd_valid[0], rd_tag[5:0]);
         n_err++;
      end
      tick();
   endtask

   task automatic test_bypass();
      idle(); dispatch(7, 12); tick();
      idle(); rd_addr = {5'd7, 5'd7};
      #2;
      n_vec++; if (rd_valid !== 2'b11) begin
         $display("FAIL bypass_pre got %b exp 11", rd_valid); n_err++; end
      cdb_valid = 1'b1; cdb_tag = 6'd12;
      #1;
      n_vec++; if (rd_valid !== 2'b00 || rd_tag !== {6'd12, 6'd12}) begin
         $display("FAIL bypass got v=%b t=%h exp v=00 t=30c", rd_valid, rd_tag); n_err++; end
      tick();
   endtask

   task automatic test_ckpt_restore_cdb();
      idle(); dispatch(4, 20); tick();
      idle(); ckpt_save = 1'b1; tick();
      idle(); dispatch(4, 21); tick();
      idle(); cdb_valid = 1'b1; cdb_tag = 6'd20; ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
      tick();
      idle(); rd_addr = {5'd5, 5'd4};
      #2;
      n_vec++; if (rd_valid[0] !== 1'b0) begin
         $display("FAIL restore_cdb_r4 got v=%b exp 0", rd_valid[0]); n_err++; end
      n_vec++; if (rd_valid[1] !== 1'b1 || rd_tag[11:6] !== 6'd9) begin
         $display("FAIL restore_r5 got v=%b t=%0d exp v=1 t=9", rd_valid[1], rd_tag[11:6]);
         n_err++;
      end
      n_vec++; if (ckpt_count !== 3'd0 || ckpt_save_id !== 2'd0) begin
         $display("FAIL restore_ptrs got cnt=%0d id=%0d exp 0/0", ckpt_count, ckpt_save_id);
         n_err++;
      end
      tick();
   endtask

   task automatic test_full_wrap();
      for (int j = 0; j < 5; j++) begin
         idle(); ckpt_save = 1'b1; tick();
         n_vec++; if (ckpt_count !== 3'(j < 4 ? j + 1 : 4) || ckpt_full !== (j >= 3)) begin
            $display("FAIL save_%0d got cnt=%0d full=%b exp cnt=%0d full=%b", j, ckpt_count,
                     ckpt_full, (j < 4 ? j + 1 : 4), (j >= 3));
            n_err++;
         end
      end
      n_vec++; if (ckpt_save_id !== 2'd0) begin
         $display("FAIL full_save_id got %0d exp 0", ckpt_save_id); n_err++; end
      idle(); ckpt_free = 1'b1; tick();
      n_vec++; if (ckpt_count !== 3'd3 || ckpt_full !== 1'b0) begin
         $display("FAIL free got cnt=%0d full=%b exp 3/0", ckpt_count, ckpt_full); n_err++; end
      idle(); ckpt_save = 1'b1; tick();
      n_vec++; if (ckpt_save_id !== 2'd1 || ckpt_count !== 3'd4) begin
         $display("FAIL wrap_save got id=%0d cnt=%0d exp 1/4", ckpt_save_id, ckpt_count);
         n_err++;
      end
      idle(); ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; ckpt_save = 1'b1; tick();
      n_vec++; if (ckpt_count !== 3'd1 || ckpt_save_id !== 2'd2 || ckpt_full !== 1'b0) begin
         $display("FAIL wrap_restore got cnt=%0d id=%0d exp 1/2", ckpt_count, ckpt_save_id);
         n_err++;
      end
      idle(); ckpt_free = 1'b1; tick();
      n_vec++; if (ckpt_count !== 3'd0) begin
         $display("FAIL free_last got cnt=%0d exp 0", ckpt_count); n_err++; end
      idle();
   endtask

   task automatic test_random();
      logic [31:0] mt;
      logic [4:0]  a;
      for (int c = 0; c < 400; c++) begin
         idle();
         dispatch_valid = ($urandom_range(0, 3) != 0);
         dispatch_wen   = ($urandom_range(0, 3) != 0);
         dispatch_addr  = 5'($urandom_range(0, 31));
         dispatch_tag   = 6'($urandom_range(0, 15));
         cdb_valid      = ($urandom_range(0, 1) == 1);
         cdb_tag = ($urandom_range(0, 2) != 0) ? m_tab.t[$urandom_range(0, 31)]
                                               : 6'($urandom_range(0, 15));
         rd_addr   = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
         ckpt_save = ($urandom_range(0, 3) == 0);
         ckpt_free = ($urandom_range(0, 4) == 0);
         if (m_q.size() > 0 && $urandom_range(0, 11) == 0) begin
            ckpt_restore    = 1'b1;
            ckpt_restore_id = 2'((m_tail + $urandom_range(0, m_q.size() - 1)) % NC);
         end
         #2;
         mt = m_match(m_tab);
         n_vec++; if (wen !== mt) begin
            $display("FAIL rand_onehot c%0d got %h exp %h", c, wen, mt); n_err++; end
         for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            n_vec++;
            if (rd_valid[k] !== (m_tab.v[a] & ~mt[a]) || rd_tag[k*6 +: 6] !== m_tab.t[a]) begin
               $display("FAIL rand_read c%0d p%0d got v=%b t=%0d exp v=%b t=%0d", c, k,
                        rd_valid[k], rd_tag[k*6 +: 6], m_tab.v[a] & ~mt[a], m_tab.t[a]);
               n_err++;
            end
         end
         n_vec++;
         if (ckpt_count !== 3'(m_q.size()) || ckpt_full !== (m_q.size() == NC) ||
             ckpt_save_id !== 2'(m_save_id())) begin
            $display("FAIL rand_ckpt c%0d got cnt=%0d full=%b id=%0d exp %0d/%b/%0d", c,
                     ckpt_count, ckpt_full, ckpt_save_id, m_q.size(), m_q.size() == NC,
                     m_save_id());
            n_err++;
         end
         tick();
      end
      idle();
   endtask

   task automatic test_async_reset();
      idle(); dispatch(1, 33); tick();
      idle(); dispatch(2, 34); ckpt_save = 1'b1; tick();
      idle(); dispatch(3, 35); rd_addr = {5'd2, 5'd1}; cdb_valid = 1'b1; cdb_tag = 6'd33;
      #1;
      n_vec++; if (wen[1] !== 1'b1 || rd_valid !== 2'b10) begin
         $display("FAIL pre_reset got wen1=%b v=%b exp 1/10", wen[1], rd_valid); n_err++; end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++; if (rd_valid !== 2'b00 || wen !== 32'd0 || ckpt_count !== 3'd0) begin
         $display("FAIL async_reset got v=%b wen=%h cnt=%0d exp 00/0/0", rd_valid, wen,
                  ckpt_count);
         n_err++;
      end
      #8 rst_n = 1'b1;
      idle();
      @(posedge clk);
      #1;
      rd_addr = {5'd3, 5'd2};
      #1;
      n_vec++; if (rd_valid !== 2'b00 || ckpt_save_id !== 2'd0) begin
         $display("FAIL post_reset got v=%b id=%0d exp 00/0", rd_valid, ckpt_save_id);
         n_err++;
      end
   endtask

   initial begin
      test_reset();
      test_fill_read_clear();
      test_collision();
      test_bypass();
      test_ckpt_restore_cdb();
      test_full_wrap();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rst_ckpt.md
Name: rst_ckpt

Overview:
- Parametrised register status table for the Tomasulo dispatch stage, generalising the fixed 32-entry, 2-read-port table.
- Tracks, per architectural register, whether a result is pending and the tag of its producer. Entries are written by dispatch and cleared by CDB broadcast.
- Adds NUM_RD read ports and NUM_CKPT branch checkpoints (snapshot/restore) for misprediction recovery.

Parameters:
- NUM_REGS, 32: architectural registers.
- ADDR_W, 5: register address width, clog2(NUM_REGS).
- TAG_W, 6: ROB/producer tag width.
- NUM_RD, 2: dispatch read ports.
- NUM_CKPT, 4: checkpoint slots; must be a power of 2.
- CKPT_W, 2: clog2(NUM_CKPT).
- ZERO_HARDWIRED, 1: when 1, writes to register 0 are ignored and it always reads not-pending.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- dispatch_tag  in  TAG_W  producer tag to record.
- dispatch_valid  in  1  dispatch slot valid.
- dispatch_addr  in  ADDR_W  destination register.
- dispatch_wen  in  1  write enable; effective only with dispatch_valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_valid  in  1  broadcast valid.
- regfile_wen_onehot  out  NUM_REGS  registers whose pending tag matches the CDB this cycle.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_tag  out  NUM_RD*TAG_W  pending tag per port.
- rd_valid  out  NUM_RD  1 = register pending.
- ckpt_save  in  1  take a snapshot.
- ckpt_save_id  out  CKPT_W  slot the next save will use (head).
- ckpt_free  in  1  release the oldest checkpoint (branch resolved correct).
- ckpt_restore  in  1  roll back to ckpt_restore_id (mispredict).
- ckpt_restore_id  in  CKPT_W  slot to restore.
- ckpt_full  out  1  count == NUM_CKPT.
- ckpt_count  out  CKPT_W+1  live checkpoints.

Behaviour:
- Reset (reset=0, asynchronous):
  - All entry valid bits = 0 and tags = 0.
  - All checkpoint contents = 0.
  - head = tail = count = 0, so ckpt_full = 0 and ckpt_count = 0.
  - Combinational outputs follow from this state.
- Dispatch write:
  - When dispatch_valid & dispatch_wen, at the next edge the entry at dispatch_addr gets valid = 1 and tag = dispatch_tag.
  - With ZERO_HARDWIRED=1, writes to address 0 are dropped.
- CDB clear:
  - regfile_wen_onehot[i] = cdb_valid & valid[i] & (tag[i] == cdb_tag). This is combinational and same-cycle.
  - At the next edge every matching entry is cleared (valid = 0); the tag is retained.
  - The same match-and-clear is applied to the valid bits of every live checkpoint slot.
- Write vs clear on the same entry in the same cycle: the dispatch write wins, leaving valid = 1 with the new tag. regfile_wen_onehot still asserts for that entry in that cycle.
- Reads (combinational from registered state, zero latency):
  - rd_valid[k] = valid[a] & ~(cdb_valid & tag[a] == cdb_tag), i.e. the CDB is bypassed.
  - rd_tag[k] = tag[a].
  - The same-cycle dispatch write is not bypassed.
- Checkpoint save:
  - Occurs when ckpt_save & ~ckpt_full & ~ckpt_restore.
  - slot[head] <= the post-update table of this cycle, i.e. including this cycle's dispatch write and CDB clear.
  - head++ (mod NUM_CKPT) and count++.
  - A save while full is dropped without side effects.
- Checkpoint free:
  - Occurs when ckpt_free & count != 0 & ~ckpt_restore.
  - tail++ and count--.
  - Save and free in the same cycle: both take effect and count is unchanged.
  - A free when empty is ignored.
- Checkpoint restore (highest priority):
  - The table <= slot[ckpt_restore_id], with the same-cycle CDB clear applied.
  - head <= ckpt_restore_id + 1 is incorrect; head <= ckpt_restore_id, which frees the restored slot and all younger slots.
  - count <= (ckpt_restore_id - tail) mod NUM_CKPT.
  - Any dispatch write, save or free in the same cycle is ignored.
  - Restoring a non-live id is illegal; the bench asserts against it.
- Wrap-around: head and tail wrap modulo NUM_CKPT; ckpt_full is derived from count, never from head == tail.
- A reset asserted mid-operation discards all entries and checkpoints immediately.

Test Plan:
- Fill/read/clear: write tag i to regs 1..31, read every reg on all NUM_RD ports, broadcast tags 1..31 one per cycle, re-read. Required: rd_valid=1 with tag=i before, regfile_wen_onehot=1<<i on each broadcast, rd_valid=0 after; reg 0 never pending.
- Collision: write reg 5 tag 9 while the CDB broadcasts tag 3, which reg 5 currently holds. Required: wen_onehot[5]=1 that cycle, then reg 5 valid=1 with tag 9.
- CDB bypass: reg 7 pending on tag 12, cdb_tag=12 with rd_addr=7. Required: rd_valid=0 in the same cycle.
- Checkpoint restore with CDB: reg 4 tag 20, save (id 0), write reg 4 tag 21, broadcast 20, restore id 0. Required: reg 4 valid=0, ckpt_count=0, ckpt_save_id=0.
- Full/wrap: 4 saves give ckpt_full=1; a 5th save is dropped; free then save gives save_id wrapping 0→1 and count=4; restore id 2 with tail=1 gives count=1 and save_id=2.
- Async reset: assert reset low mid-fill between clock edges. Required: all rd_valid=0, wen_onehot=0 and ckpt_count=0 immediately, before the next edge.
